sema_ctrl_n: RTL and testbench

Parametrised, clocked traffic-light controller for N vehicle directions plus one pedestrian crossing. It generalises the two-direction semaphore FSM in three ways: the state register is internal, phase durations are counted on a tick strobe, and requests are latched and served in round-robin order. It sits between the debounced request inputs and the lamp drivers in the semaphore top level.

---
 rtl/sema_pkg.sv | 32 +++
 rtl/sema_rr_arb.sv | 40 ++++
 rtl/sema_ctrl_n.sv | 231 +++++++++++++++++++++++
 tb/tb_sema_ctrl_n.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sema_pkg.sv
// sema_pkg -- shared definitions for the sema_ctrl_n traffic-light controller.
//   Lamp encodings for vehicle ({g,y,r}) and pedestrian ({walk,dont}) heads,
//   the phase enumeration (values are visible on the controller's phase port),
//   and a helper that sizes the phase timer from the longest phase duration.
package sema_pkg;

  localparam logic [2:0] GYR_GREEN  = 3'b100;
  localparam logic [2:0] GYR_YELLOW = 3'b010;
  localparam logic [2:0] GYR_RED    = 3'b001;

  localparam logic [1:0] PED_WALK = 2'b10;
  localparam logic [1:0] PED_DONT = 2'b01;
  localparam logic [1:0] PED_DARK = 2'b00;

  typedef enum logic [2:0] {
    PH_GREEN  = 3'd0,
    PH_YELLOW = 3'd1,
    PH_ALLRED = 3'd2,
    PH_WALK   = 3'd3,
    PH_BLINK  = 3'd4
  } phase_e;

  // Bits needed to hold a timer value in 0..max_dur.
  function automatic int tmr_width(input int max_dur);
    if (max_dur < 2) begin
      return 1;
    end else begin
      return $clog2(max_dur + 1);
    end
  endfunction

endpackage

// File: rtl/sema_rr_arb.sv
// sema_rr_arb -- combinational round-robin picker.
//   pend  : request vector, one bit per direction
//   start : index that gets first look; search wraps modulo N
//   valid : at least one pending bit
//   idx   : first pending index at or after start (wrapping)
module sema_rr_arb #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] idx
);

  int j_s;

  // Scan from the farthest candidate back to start so the last hit wins,
  // which leaves idx holding the nearest pending direction after start.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j_s   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j_s = int'(start) + i;
      if (j_s >= N) begin
        j_s = j_s - N;
      end else begin
        j_s = j_s;
      end
      if (pend[j_s]) begin
        valid = 1'b1;
        idx   = W'(j_s);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/sema_ctrl_n.sv
// sema_ctrl_n -- N-direction traffic-light controller with one pedestrian
// crossing. Phase timers advance on the tick strobe; vehicle and pedestrian
// requests are latched and served round-robin, pedestrians first.
//   clk      : rising-edge clock
//   rst      : asynchronous, active-high reset
//   tick     : one-cycle timing strobe
//   car_req  : per-direction vehicle requests (level or pulse)
//   ped_req  : pedestrian request (level or pulse)
//   lamp_gyr : per-direction {g,y,r}, direction d at [3d+2:3d]
//   ped_gr   : 10 walk, 01 don't walk, 00 dark
//   cur_dir  : direction owning (or last owning) green
//   phase    : current phase encoding (see sema_pkg::phase_e)
// Build option: define SEMA_ALLRED_EN to insert an all-red clearance phase of
// ALLRED_T ticks after every yellow.
module sema_ctrl_n
  import sema_pkg::*;
#(
  parameter int N_DIR    = 3,
  parameter int GREEN_T  = 4,
  parameter int YELLOW_T = 2,
  parameter int WALK_T   = 3,
  parameter int BLINK_N  = 2,
  parameter int ALLRED_T = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [N_DIR-1:0]         car_req,
  input  logic                     ped_req,
  output logic [3*N_DIR-1:0]       lamp_gyr,
  output logic [1:0]               ped_gr,
  output logic [$clog2(N_DIR)-1:0] cur_dir,
  output logic [2:0]               phase
);

  localparam int DW      = $clog2(N_DIR);
  localparam int BLINK_T = 2 * BLINK_N;
  localparam int MAX_A   = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int MAX_B   = (WALK_T > BLINK_T) ? WALK_T : BLINK_T;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_T   = (MAX_C > ALLRED_T) ? MAX_C : ALLRED_T;
  localparam int TW      = tmr_width(MAX_T);

  localparam logic [3*N_DIR-1:0] LAMP_RST = {{(N_DIR-1){GYR_RED}}, GYR_GREEN};

  phase_e             phase_r,     phase_nxt_s;
  logic [DW-1:0]      cur_dir_r,   cur_dir_nxt_s;
  logic [TW-1:0]      timer_r,     timer_nxt_s;
  logic               blink_par_r, blink_par_nxt_s;
  logic               tgt_walk_r,  tgt_walk_nxt_s;
  logic [DW-1:0]      tgt_dir_r,   tgt_dir_nxt_s;
  logic [N_DIR-1:0]   car_pend_r;
  logic               ped_pend_r;
  logic [N_DIR-1:0]   car_clr_s;
  logic               ped_clr_s;
  logic               go_tgt_s;
  logic [N_DIR-1:0]   arb_pend_s;
  logic [DW-1:0]      arb_start_s;
  logic               arb_valid_s;
  logic [DW-1:0]      arb_idx_s;

  // Vehicle lamp vector for a given phase and owning direction.
  function automatic logic [3*N_DIR-1:0] lamp_dec(input phase_e ph, input logic [DW-1:0] d);
    logic [3*N_DIR-1:0] v;
    for (int k = 0; k < N_DIR; k++) begin
      if ((DW'(k) == d) && (ph == PH_GREEN)) begin
        v[3*k +: 3] = GYR_GREEN;
      end else if ((DW'(k) == d) && (ph == PH_YELLOW)) begin
        v[3*k +: 3] = GYR_YELLOW;
      end else begin
        v[3*k +: 3] = GYR_RED;
      end
    end
    return v;
  endfunction

  // Pedestrian head for a given phase; blink parity 0 is the dark half.
  function automatic logic [1:0] ped_dec(input phase_e ph, input logic par);
    case (ph)
      PH_WALK:  return PED_WALK;
      PH_BLINK: return par ? PED_WALK : PED_DARK;
      default:  return PED_DONT;
    endcase
  endfunction

  assign phase   = phase_r;
  assign cur_dir = cur_dir_r;

  // Round-robin candidates: in GREEN the current owner is excluded so the
  // light only moves when someone else is waiting; after BLINK it may return.
  always_comb begin
    arb_pend_s  = car_pend_r;
    arb_start_s = (cur_dir_r == DW'(N_DIR - 1)) ? '0 : (cur_dir_r + DW'(1));
    if (phase_r == PH_GREEN) begin
      arb_pend_s[cur_dir_r] = 1'b0;
    end else begin
      arb_pend_s = car_pend_r;
    end
  end

  sema_rr_arb #(
    .N (N_DIR),
    .W (DW)
  ) u_arb (
    .pend  (arb_pend_s),
    .start (arb_start_s),
    .valid (arb_valid_s),
    .idx   (arb_idx_s)
  );

  // Next-state logic: phase changes only on a tick that finds timer at 1.
  always_comb begin
    phase_nxt_s     = phase_r;
    cur_dir_nxt_s   = cur_dir_r;
    timer_nxt_s     = timer_r;
    blink_par_nxt_s = blink_par_r;
    tgt_walk_nxt_s  = tgt_walk_r;
    tgt_dir_nxt_s   = tgt_dir_r;
    car_clr_s       = '0;
    ped_clr_s       = 1'b0;
    go_tgt_s        = 1'b0;

    if (tick && (timer_r == TW'(1))) begin
      case (phase_r)
        PH_GREEN: begin
          if (ped_pend_r) begin
            phase_nxt_s    = PH_YELLOW;
            tgt_walk_nxt_s = 1'b1;
            timer_nxt_s    = TW'(YELLOW_T);
          end else if (arb_valid_s) begin
            phase_nxt_s    = PH_YELLOW;
            tgt_walk_nxt_s = 1'b0;
            tgt_dir_nxt_s  = arb_idx_s;
            timer_nxt_s    = TW'(YELLOW_T);
          end else begin
            // Nobody else waiting: timer stays at 1 so every tick re-checks.
            timer_nxt_s = timer_r;
          end
        end
        PH_YELLOW: begin
`ifdef SEMA_ALLRED_EN
          phase_nxt_s = PH_ALLRED;
          timer_nxt_s = TW'(ALLRED_T);
`else
          go_tgt_s = 1'b1;
`endif
        end
        PH_ALLRED: begin
          go_tgt_s = 1'b1;
        end
        PH_WALK: begin
          phase_nxt_s     = PH_BLINK;
          timer_nxt_s     = TW'(BLINK_T);
          blink_par_nxt_s = 1'b0;
        end
        PH_BLINK: begin
          phase_nxt_s     = PH_GREEN;
          timer_nxt_s     = TW'(GREEN_T);
          blink_par_nxt_s = 1'b0;
          if (arb_valid_s) begin
            cur_dir_nxt_s = arb_idx_s;
            car_clr_s     = N_DIR'(1) << arb_idx_s;
          end else begin
            car_clr_s = N_DIR'(1) << cur_dir_r;
          end
        end
        default: begin
          phase_nxt_s     = PH_GREEN;
          cur_dir_nxt_s   = '0;
          timer_nxt_s     = TW'(GREEN_T);
          blink_par_nxt_s = 1'b0;
        end
      endcase
    end else if (tick) begin
      timer_nxt_s = timer_r - TW'(1);
      if (phase_r == PH_BLINK) begin
        blink_par_nxt_s = ~blink_par_r;
      end else begin
        blink_par_nxt_s = blink_par_r;
      end
    end else begin
      timer_nxt_s = timer_r;
    end

    // Entry into the phase chosen when GREEN last expired.
    if (go_tgt_s) begin
      if (tgt_walk_r) begin
        phase_nxt_s = PH_WALK;
        timer_nxt_s = TW'(WALK_T);
        ped_clr_s   = 1'b1;
      end else begin
        phase_nxt_s   = PH_GREEN;
        cur_dir_nxt_s = tgt_dir_r;
        timer_nxt_s   = TW'(GREEN_T);
        car_clr_s     = N_DIR'(1) << tgt_dir_r;
      end
    end else begin
      ped_clr_s = ped_clr_s;
    end
  end

  // State, pending requests and lamp outputs; outputs decode the next state
  // so they change on the same edge as the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r     <= PH_GREEN;
      cur_dir_r   <= '0;
      timer_r     <= TW'(GREEN_T);
      blink_par_r <= 1'b0;
      tgt_walk_r  <= 1'b0;
      tgt_dir_r   <= '0;
      car_pend_r  <= '0;
      ped_pend_r  <= 1'b0;
      lamp_gyr    <= LAMP_RST;
      ped_gr      <= PED_DONT;
    end else begin
      phase_r     <= phase_nxt_s;
      cur_dir_r   <= cur_dir_nxt_s;
      timer_r     <= timer_nxt_s;
      blink_par_r <= blink_par_nxt_s;
      tgt_walk_r  <= tgt_walk_nxt_s;
      tgt_dir_r   <= tgt_dir_nxt_s;
      // A request coinciding with its clear stays pending.
      car_pend_r  <= (car_pend_r & ~car_clr_s) | car_req;
      ped_pend_r  <= (ped_pend_r & ~ped_clr_s) | ped_req;
      lamp_gyr    <= lamp_dec(phase_nxt_s, cur_dir_nxt_s);
      ped_gr      <= ped_dec(phase_nxt_s, blink_par_nxt_s);
    end
  end

endmodule

// File: tb/tb_sema_ctrl_n.sv
// tb_sema_ctrl_n -- directed bench for sema_ctrl_n (N_DIR=3, default timing,
// tick=1 unless a scenario freezes it). Expected traces are hand-built per
// scenario; an extra all-red step is expected when SEMA_ALLRED_EN is defined.
module tb_sema_ctrl_n;

`ifdef SEMA_ALLRED_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic [2:0] car_req = 3'b000;
  logic       ped_req = 1'b0;
  logic [8:0] lamp_gyr;
  logic [1:0] ped_gr;
  logic [1:0] cur_dir;
  logic [2:0] phase;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [8:0] lamp;
    logic [1:0] ped;
    logic [2:0] ph;
    logic [1:0] dir;
  } exp_t;

  sema_ctrl_n #(
    .N_DIR    (3),
    .GREEN_T  (4),
    .YELLOW_T (2),
    .WALK_T   (3),
    .BLINK_N  (2),
    .ALLRED_T (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .car_req  (car_req),
    .ped_req  (ped_req),
    .lamp_gyr (lamp_gyr),
    .ped_gr   (ped_gr),
    .cur_dir  (cur_dir),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] lamp_of(input int d, input logic [2:0] code);
    logic [8:0] v;
    v = 9'b001_001_001;
    v[3*d +: 3] = code;
    return v;
  endfunction

  function automatic exp_t grn(input int d);
    return '{lamp: lamp_of(d, 3'b100), ped: 2'b01, ph: 3'd0, dir: 2'(d)};
  endfunction
  function automatic exp_t ylw(input int d);
    return '{lamp: lamp_of(d, 3'b010), ped: 2'b01, ph: 3'd1, dir: 2'(d)};
  endfunction
  function automatic exp_t alr(input int d);
    return '{lamp: 9'b001_001_001, ped: 2'b01, ph: 3'd2, dir: 2'(d)};
  endfunction
  function automatic exp_t wlk(input int d);
    return '{lamp: 9'b001_001_001, ped: 2'b10, ph: 3'd3, dir: 2'(d)};
  endfunction
  function automatic exp_t blk(input int d, input logic on);
    return '{lamp: 9'b001_001_001, ped: (on ? 2'b10 : 2'b00), ph: 3'd4, dir: 2'(d)};
  endfunction

  task automatic reset_dut();
    rst     = 1'b1;
    tick    = 1'b1;
    car_req = 3'b000;
    ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t obs;
    exp_t e;
    reset_dut();
    e = grn(0);
    for (int i = 0; i < 20; i++) begin
      obs = {lamp_gyr, ped_gr, phase, cur_dir};
      vec_cnt++;
      if (obs !== e) begin
        err_cnt++;
        $display("FAIL reset_idle[%0d]: got lamp=%b ped=%b phase=%0d dir=%0d, want lamp=%b ped=%b phase=%0d dir=%0d",
                 i, obs.lamp, obs.ped, obs.ph, obs.dir, e.lamp, e.ped, e.ph, e.dir);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_car_pulse();
    exp_t q[$];
    exp_t obs;
    reset_dut();
    car_req = 3'b100;
    repeat (4) q.push_back(grn(0));
    repeat (2) q.push_back(ylw(0));
    if (AR != 0) q.push_back(alr(0));
    repeat (4) q.push_back(grn(2));
    for (int i = 0; i < q.size(); i++) begin
      if (i == 1) car_req = 3'b000;
      obs = {lamp_gyr, ped_gr, phase, cur_dir};
      vec_cnt++;
      if (obs !== q[i]) begin
        err_cnt++;
        $display("FAIL car_pulse[%0d]: got lamp=%b ped=%b phase=%0d dir=%0d, want lamp=%b ped=%b phase=%0d dir=%0d",
                 i, obs.lamp, obs.ped, obs.ph, obs.dir, q[i].lamp, q[i].ped, q[i].ph, q[i].dir);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ped_priority();
    exp_t q[$];
    exp_t obs;
    reset_dut();
    ped_req = 1'b1;
    car_req = 3'b010;
    repeat (4) q.push_back(grn(0));
    repeat (2) q.push_back(ylw(0));
    if (AR != 0) q.push_back(alr(0));
    repeat (3) q.push_back(wlk(0));
    q.push_back(blk(0, 1'b0));
    q.push_back(blk(0, 1'b1));
    q.push_back(blk(0, 1'b0));
    q.push_back(blk(0, 1'b1));
    repeat (3) q.push_back(grn(1));
    for (int i = 0; i < q.size(); i++) begin
      if (i == 1) begin
        ped_req = 1'b0;
        car_req = 3'b000;
      end
      obs = {lamp_gyr, ped_gr, phase, cur_dir};
      vec_cnt++;
      if (obs !== q[i]) begin
        err_cnt++;
        $display("FAIL ped_priority[%0d]: got lamp=%b ped=%b phase=%0d dir=%0d, want lamp=%b ped=%b phase=%0d dir=%0d",
                 i, obs.lamp, obs.ped, obs.ph, obs.dir, q[i].lamp, q[i].ped, q[i].ph, q[i].dir);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_held();
    exp_t q[$];
    exp_t obs;
    int   order[5] = '{1, 2, 0, 1, 2};
    reset_dut();
    car_req = 3'b010;
    repeat (4) q.push_back(grn(0));
    repeat (2) q.push_back(ylw(0));
    if (AR != 0) q.push_back(alr(0));
    for (int k = 0; k < 4; k++) begin
      repeat (4) q.push_back(grn(order[k]));
      repeat (2) q.push_back(ylw(order[k]));
      if (AR != 0) q.push_back(alr(order[k]));
    end
    repeat (2) q.push_back(grn(order[4]));
    for (int i = 0; i < q.size(); i++) begin
      if (i == 1) car_req = 3'b000;
      if (i == 6 + AR) car_req = 3'b111;
      obs = {lamp_gyr, ped_gr, phase, cur_dir};
      vec_cnt++;
      if (obs !== q[i]) begin
        err_cnt++;
        $display("FAIL rr_held[%0d]: got lamp=%b ped=%b phase=%0d dir=%0d, want lamp=%b ped=%b phase=%0d dir=%0d",
                 i, obs.lamp, obs.ped, obs.ph, obs.dir, q[i].lamp, q[i].ped, q[i].ph, q[i].dir);
      end
      @(negedge clk);
    end
    car_req = 3'b000;
  endtask

  task automatic test_tick_freeze();
    exp_t q[$];
    exp_t obs;
    reset_dut();
    tick    = 1'b0;
    car_req = 3'b100;
    repeat (14) q.push_back(grn(0));
    repeat (2) q.push_back(ylw(0));
    for (int i = 0; i < q.size(); i++) begin
      if (i == 1) car_req = 3'b000;
      if (i == 10) tick = 1'b1;
      obs = {lamp_gyr, ped_gr, phase, cur_dir};
      vec_cnt++;
      if (obs !== q[i]) begin
        err_cnt++;
        $display("FAIL tick_freeze[%0d]: got lamp=%b ped=%b phase=%0d dir=%0d, want lamp=%b ped=%b phase=%0d dir=%0d",
                 i, obs.lamp, obs.ped, obs.ph, obs.dir, q[i].lamp, q[i].ped, q[i].ph, q[i].dir);
      end
      @(negedge clk);
    end
    tick = 1'b1;
  endtask

  task automatic test_async_reset();
    exp_t q[$];
    exp_t obs;
    exp_t e;
    reset_dut();
    ped_req = 1'b1;
    car_req = 3'b010;
    repeat (4) q.push_back(grn(0));
    repeat (2) q.push_back(ylw(0));
    if (AR != 0) q.push_back(alr(0));
    repeat (3) q.push_back(wlk(0));
    q.push_back(blk(0, 1'b0));
    for (int i = 0; i < q.size(); i++) begin
      if (i == 1) begin
        ped_req = 1'b0;
        car_req = 3'b000;
      end
      obs = {lamp_gyr, ped_gr, phase, cur_dir};
      vec_cnt++;
      if (obs !== q[i]) begin
        err_cnt++;
        $display("FAIL async_rst_pre[%0d]: got lamp=%b ped=%b phase=%0d dir=%0d, want lamp=%b ped=%b phase=%0d dir=%0d",
                 i, obs.lamp, obs.ped, obs.ph, obs.dir, q[i].lamp, q[i].ped, q[i].ph, q[i].dir);
      end
      @(negedge clk);
    end
    // Mid-BLINK with car_pend[1] still waiting: assert reset between edges.
    #2;
    rst = 1'b1;
    #1;
    e   = grn(0);
    obs = {lamp_gyr, ped_gr, phase, cur_dir};
    vec_cnt++;
    if (obs !== e) begin
      err_cnt++;
      $display("FAIL async_rst_now: got lamp=%b ped=%b phase=%0d dir=%0d, want lamp=%b ped=%b phase=%0d dir=%0d",
               obs.lamp, obs.ped, obs.ph, obs.dir, e.lamp, e.ped, e.ph, e.dir);
    end
    @(negedge clk);
    rst = 1'b0;
    // The cleared request must not move the light away from direction 0.
    for (int i = 0; i < 8; i++) begin
      obs = {lamp_gyr, ped_gr, phase, cur_dir};
      vec_cnt++;
      if (obs !== e) begin
        err_cnt++;
        $display("FAIL async_rst_post[%0d]: got lamp=%b ped=%b phase=%0d dir=%0d, want lamp=%b ped=%b phase=%0d dir=%0d",
                 i, obs.lamp, obs.ped, obs.ph, obs.dir, e.lamp, e.ped, e.ph, e.dir);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_car_pulse();
    test_ped_priority();
    test_rr_held();
    test_tick_freeze();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
